// File: rtl/sm_mem_copy_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module : sm_mem_copy_engine_pkg
// Brief  : Shared memory message definitions used by the copy engine.
//          Defines the message type codes and the field widths of the
//          standard req/resp format. Both messages are packed MSB to LSB as
//          {type, opaque, addr, len, data}.
// Config : SM_MEM_COPY_ENGINE_CHECK_EN (response checking in the top module)
// Rev    : 1.0  initial release
// ============================================================================
package sm_mem_copy_engine_pkg;

  localparam int MEM_TYPE_NBITS = 3;

  localparam logic [MEM_TYPE_NBITS-1:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [MEM_TYPE_NBITS-1:0] MEM_TYPE_WRITE = 3'd1;

  // Width of the len field, which encodes bytes-per-access (0 = full word)
  function automatic int mem_len_nbits(input int d);
    return (d / 8 > 1) ? $clog2(d / 8) : 1;
  endfunction

  // Total request message width for opaque/addr/data widths o/a/d
  function automatic int mem_req_nbits(input int o, input int a, input int d);
    return MEM_TYPE_NBITS + o + a + mem_len_nbits(d) + d;
  endfunction

  // Total response message width; the response echoes addr as well
  function automatic int mem_resp_nbits(input int o, input int a, input int d);
    return MEM_TYPE_NBITS + o + a + mem_len_nbits(d) + d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm_mem_copy_engine_addrgen.sv
`default_nettype none
// ============================================================================
// Module : sm_mem_copy_engine_addrgen
// Brief  : Holds the latched copy command (src, dst, n) and the word counter
//          i. Produces the read/write byte addresses, the opaque tag and the
//          flag marking the final word.
// Rev    : 1.0  initial release
// ============================================================================
module sm_mem_copy_engine_addrgen
  import sm_mem_copy_engine_pkg::*;
#(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter int p_count_nbits  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic                      incr,
  input  logic [p_addr_nbits-1:0]   src_in,
  input  logic [p_addr_nbits-1:0]   dst_in,
  input  logic [p_count_nbits-1:0]  nwords_in,
  output logic [p_addr_nbits-1:0]   rd_addr,
  output logic [p_addr_nbits-1:0]   wr_addr,
  output logic [p_opaque_nbits-1:0] opaque,
  output logic                      last
);

  localparam logic [p_addr_nbits-1:0] c_word_bytes = p_addr_nbits'(p_data_nbits / 8);

  logic [p_addr_nbits-1:0]  src_q, src_d;
  logic [p_addr_nbits-1:0]  dst_q, dst_d;
  logic [p_count_nbits-1:0] n_q, n_d;
  logic [p_count_nbits-1:0] i_q, i_d;
  logic [p_addr_nbits-1:0]  offset;
  logic [p_count_nbits:0]   i_plus1;

  // Command latch and word counter next-state
  always_comb begin
    src_d = src_q;
    dst_d = dst_q;
    n_d   = n_q;
    i_d   = i_q;
    if (load) begin
      src_d = src_in;
      dst_d = dst_in;
      n_d   = nwords_in;
      i_d   = '0;
    end else if (incr) begin
      i_d = i_q + 1'b1;
    end
  end

  // Command and counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      src_q <= '0;
      dst_q <= '0;
      n_q   <= '0;
      i_q   <= '0;
    end else begin
      src_q <= src_d;
      dst_q <= dst_d;
      n_q   <= n_d;
      i_q   <= i_d;
    end
  end

  // Byte offset of word i; all address sums wrap modulo 2^a
  assign offset  = p_addr_nbits'(i_q) * c_word_bytes;
  assign rd_addr = src_q + offset;
  assign wr_addr = dst_q + offset;
  assign opaque  = p_opaque_nbits'(i_q);

  // One extra bit so n = 2^count-1 terminates correctly
  assign i_plus1 = {1'b0, i_q} + (p_count_nbits + 1)'(1);
  assign last    = (i_plus1 == {1'b0, n_q});

endmodule
`default_nettype wire

// File: rtl/sm_mem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module : sm_mem_copy_engine
// Brief  : Memory-request initiator copying n words from src to dst, one
//          transaction outstanding: read word i, write word i, advance.
//          Accepts a go command and reports completion over val/rdy.
// Config : SM_MEM_COPY_ENGINE_CHECK_EN - when defined, each accepted
//          response is checked (opaque, type, addr) and mismatches raise a
//          sticky done_err; when undefined done_err is tied low.
// Rev    : 1.0  initial release
// ============================================================================
module sm_mem_copy_engine
  import sm_mem_copy_engine_pkg::*;
#(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter int p_count_nbits  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     go_val,
  output logic                     go_rdy,
  input  logic [p_addr_nbits-1:0]  go_src,
  input  logic [p_addr_nbits-1:0]  go_dst,
  input  logic [p_count_nbits-1:0] go_nwords,
  output logic                     done_val,
  input  logic                     done_rdy,
  output logic                     done_err,
  output logic                     busy,
  output logic                     memreq_val,
  input  logic                     memreq_rdy,
  output logic [mem_req_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)-1:0]   memreq_msg,
  input  logic                     memresp_val,
  output logic                     memresp_rdy,
  input  logic [mem_resp_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)-1:0] memresp_msg
);

  localparam int c_len_nbits = mem_len_nbits(p_data_nbits);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  state_e                    state_q, state_d;
  logic [p_data_nbits-1:0]   wdata_q, wdata_d;
  logic                      err_q, err_d;

  logic                      load, incr, last;
  logic [p_addr_nbits-1:0]   rd_addr, wr_addr;
  logic [p_opaque_nbits-1:0] opaque;

  logic [MEM_TYPE_NBITS-1:0] req_type;
  logic [p_addr_nbits-1:0]   req_addr;
  logic [p_data_nbits-1:0]   req_data;

  logic [MEM_TYPE_NBITS-1:0] resp_type;
  logic [p_opaque_nbits-1:0] resp_opaque;
  logic [p_addr_nbits-1:0]   resp_addr;
  logic [c_len_nbits-1:0]    resp_len;
  logic [p_data_nbits-1:0]   resp_data;
  logic                      resp_bad;
  logic                      unused_resp;

  assign {resp_type, resp_opaque, resp_addr, resp_len, resp_data} = memresp_msg;

  sm_mem_copy_engine_addrgen #(
    .p_opaque_nbits (p_opaque_nbits),
    .p_addr_nbits   (p_addr_nbits),
    .p_data_nbits   (p_data_nbits),
    .p_count_nbits  (p_count_nbits)
  ) u_addrgen (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .incr      (incr),
    .src_in    (go_src),
    .dst_in    (go_dst),
    .nwords_in (go_nwords),
    .rd_addr   (rd_addr),
    .wr_addr   (wr_addr),
    .opaque    (opaque),
    .last      (last)
  );

  // State, write-data and error registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and handshake outputs; request fields depend only on state
  always_comb begin
    state_d     = state_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    load        = 1'b0;
    incr        = 1'b0;
    go_rdy      = 1'b0;
    done_val    = 1'b0;
    memreq_val  = 1'b0;
    memresp_rdy = 1'b0;
    req_type    = MEM_TYPE_READ;
    req_addr    = rd_addr;
    req_data    = '0;
    case (state_q)
      ST_IDLE: begin
        go_rdy = 1'b1;
        if (go_val) begin
          load    = 1'b1;
          err_d   = 1'b0;
          state_d = (go_nwords == '0) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        memreq_val = 1'b1;
        if (memreq_rdy) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        memresp_rdy = 1'b1;
        if (memresp_val) begin
          wdata_d = resp_data;
          err_d   = err_q | resp_bad;
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        memreq_val = 1'b1;
        req_type   = MEM_TYPE_WRITE;
        req_addr   = wr_addr;
        req_data   = wdata_q;
        if (memreq_rdy) state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        memresp_rdy = 1'b1;
        if (memresp_val) begin
          incr    = 1'b1;
          err_d   = err_q | resp_bad;
          state_d = last ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_DONE: begin
        done_val = 1'b1;
        if (done_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign memreq_msg = {req_type, opaque, req_addr, {c_len_nbits{1'b0}}, req_data};

`ifdef SM_MEM_COPY_ENGINE_CHECK_EN
  logic [MEM_TYPE_NBITS-1:0] exp_type;
  logic [p_addr_nbits-1:0]   exp_addr;

  assign exp_type    = (state_q == ST_WR_WAIT) ? MEM_TYPE_WRITE : MEM_TYPE_READ;
  assign exp_addr    = (state_q == ST_WR_WAIT) ? wr_addr : rd_addr;
  assign resp_bad    = (resp_opaque != opaque) || (resp_type != exp_type) ||
                       (resp_addr != exp_addr);
  assign done_err    = err_q;
  assign unused_resp = &{1'b0, resp_len};

`ifndef VC_ASSERT_NOT_X
`define VC_ASSERT_NOT_X(sig) assert (!$isunknown(sig))
`endif
  // Handshake inputs from neighbours must never be X once out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      `VC_ASSERT_NOT_X(memresp_val);
      `VC_ASSERT_NOT_X(done_rdy);
    end
  end
`else
  assign resp_bad    = 1'b0;
  assign done_err    = 1'b0;
  assign unused_resp = &{1'b0, resp_type, resp_opaque, resp_addr, resp_len};
`endif

endmodule
`default_nettype wire

// File: tb/tb_sm_mem_copy_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_sm_mem_copy_engine
// Brief  : Scoreboard bench for sm_mem_copy_engine with a behavioural memory
//          responder and a word-level copy reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sm_mem_copy_engine;
  import sm_mem_copy_engine_pkg::*;

  localparam int O = 8;
  localparam int A = 32;
  localparam int D = 32;
  localparam int C = 16;

  typedef struct packed {
    logic [2:0]  t;
    logic [7:0]  op;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } msg_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          go_val = 1'b0;
  logic          go_rdy;
  logic [31:0]   go_src = '0;
  logic [31:0]   go_dst = '0;
  logic [15:0]   go_nwords = '0;
  logic          done_val;
  logic          done_rdy = 1'b0;
  logic          done_err;
  logic          busy;
  logic          memreq_val;
  logic          memreq_rdy;
  logic [76:0]   memreq_msg;
  logic          memresp_val;
  logic          memresp_rdy;
  msg_t          resp_m;
  msg_t          req_m;

  assign req_m = memreq_msg;

  always #5 clk = ~clk;

  sm_mem_copy_engine #(
    .p_opaque_nbits (O),
    .p_addr_nbits   (A),
    .p_data_nbits   (D),
    .p_count_nbits  (C)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .go_val      (go_val),
    .go_rdy      (go_rdy),
    .go_src      (go_src),
    .go_dst      (go_dst),
    .go_nwords   (go_nwords),
    .done_val    (done_val),
    .done_rdy    (done_rdy),
    .done_err    (done_err),
    .busy        (busy),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memreq_msg  (memreq_msg),
    .memresp_val (memresp_val),
    .memresp_rdy (memresp_rdy),
    .memresp_msg (resp_m)
  );

  int vectors = 0;
  int miscompares = 0;
  int req_fires = 0;
  bit stall_en = 1'b0;
  bit corrupt_once = 1'b0;

  logic [31:0] tb_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  msg_t        exp_req_q [$];
  bit          exp_done_q [$];
  msg_t        pend_q [$];

`ifdef SM_MEM_COPY_ENGINE_CHECK_EN
  localparam bit EXP_ERR_ON_CORRUPT = 1'b1;
`else
  localparam bit EXP_ERR_ON_CORRUPT = 1'b0;
`endif

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  function automatic logic [31:0] tb_rd(input logic [31:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    tb_mem[a]  = d;
    ref_mem[a] = d;
  endtask

  // Memory responder: accepts requests, services them, returns responses in order
  initial begin
    msg_t rq;
    msg_t rs;
    bit   rf;
    bit   sf;
    bit   rst_s;
    memreq_rdy  = 1'b0;
    memresp_val = 1'b0;
    resp_m      = '0;
    forever begin
      @(negedge clk);
      rst_s = !reset;
      rf    = memreq_val && memreq_rdy;
      rq    = req_m;
      sf    = memresp_val && memresp_rdy;
      @(posedge clk);
      #1;
      if (rst_s) begin
        pend_q.delete();
        memresp_val = 1'b0;
      end else begin
        if (sf) memresp_val = 1'b0;
        if (rf) begin
          rs     = rq;
          rs.len = 2'd0;
          if (rq.t == MEM_TYPE_WRITE) begin
            tb_mem[rq.addr] = rq.data;
            rs.data = 32'h0;
          end else begin
            rs.data = tb_rd(rq.addr);
          end
          if (corrupt_once && rq.op == 8'h00) begin
            rs.op = 8'h05;
            corrupt_once = 1'b0;
          end
          pend_q.push_back(rs);
        end
        if (!memresp_val && pend_q.size() > 0 &&
            (!stall_en || $urandom_range(0, 2) != 0)) begin
          resp_m      = pend_q.pop_front();
          memresp_val = 1'b1;
        end
      end
      memreq_rdy = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor: pops expected requests/completions and checks handshake holds
  initial begin
    msg_t prev;
    bit   stalled = 1'b0;
    bit   done_stalled = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stalled      = 1'b0;
        done_stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("req_hold_val", memreq_val, 1'b1);
          check("req_hold_msg", req_m, prev);
        end
        if (done_stalled) check("done_hold_val", done_val, 1'b1);
        if (memreq_val && memreq_rdy) begin
          req_fires++;
          if (exp_req_q.size() == 0) fail_now("req_unexpected");
          else check("req_msg", req_m, exp_req_q.pop_front());
        end
        if (done_val && done_rdy) begin
          if (exp_done_q.size() == 0) fail_now("done_unexpected");
          else check("done_err", done_err, exp_done_q.pop_front());
        end
        stalled      = memreq_val && !memreq_rdy;
        prev         = req_m;
        done_stalled = done_val && !done_rdy;
      end
    end
  end

  // Reference model: a copy is n sequential word moves in address order
  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst,
                            input int n, input bit exp_err);
    logic [31:0] ar;
    logic [31:0] aw;
    logic [31:0] d;
    bit ok = 1'b0;
    for (int k = 0; k < n; k++) begin
      ar = src + 32'(k) * 32'd4;
      aw = dst + 32'(k) * 32'd4;
      d  = ref_rd(ar);
      exp_req_q.push_back('{t: MEM_TYPE_READ,  op: 8'(k), addr: ar, len: 2'd0, data: 32'h0});
      exp_req_q.push_back('{t: MEM_TYPE_WRITE, op: 8'(k), addr: aw, len: 2'd0, data: d});
      ref_mem[aw] = d;
    end
    exp_done_q.push_back(exp_err);
    @(posedge clk);
    #1;
    go_src    = src;
    go_dst    = dst;
    go_nwords = 16'(n);
    go_val    = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (go_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("go_accept_timeout");
    @(posedge clk);
    #1;
    go_val = 1'b0;
  endtask

  task automatic wait_done(input int hold);
    int  held = 0;
    bit  ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (done_val && done_rdy) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
        done_rdy = 1'b0;
        break;
      end
      if (done_val) held++;
      @(posedge clk);
      #1;
      if (done_val && held >= hold) done_rdy = 1'b1;
    end
    if (!ok) fail_now("done_timeout");
  endtask

  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int n,
                          input int hold, input bit exp_err);
    int f0;
    f0 = req_fires;
    start_copy(src, dst, n, exp_err);
    wait_done(hold);
    check("req_count", 32'(req_fires - f0), 32'(2 * n));
    for (int k = 0; k < n; k++)
      check("dst_data", tb_rd(dst + 32'(k) * 32'd4), ref_rd(dst + 32'(k) * 32'd4));
    @(negedge clk);
    check("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int n;
    logic [31:0] s;
    logic [31:0] d;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_go_rdy", go_rdy, 1'b1);
    check("rst_done_val", done_val, 1'b0);
    check("rst_memreq_val", memreq_val, 1'b0);
    check("rst_memresp_rdy", memresp_rdy, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done_err", done_err, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Basic four-word copy
    preload(32'h100, 32'h11);
    preload(32'h104, 32'h22);
    preload(32'h108, 32'h33);
    preload(32'h10C, 32'h44);
    run_copy(32'h100, 32'h200, 4, 0, 1'b0);
    check("basic_w3", tb_rd(32'h20C), 32'h44);

    // Zero-length copy completes one cycle after acceptance
    begin
      int f0;
      f0 = req_fires;
      start_copy(32'h300, 32'h400, 0, 1'b0);
      @(negedge clk);
      check("n0_done_next", done_val, 1'b1);
      wait_done(0);
      check("n0_no_req", 32'(req_fires - f0), 32'd0);
    end

    // Source wraps past the top of the address space
    preload(32'hFFFF_FFFC, 32'hCAFE_0001);
    preload(32'h0000_0000, 32'hCAFE_0002);
    run_copy(32'hFFFF_FFFC, 32'h500, 2, 0, 1'b0);
    check("wrap_w1", tb_rd(32'h504), 32'hCAFE_0002);

    // Stalled responder and slow completion consumer
    stall_en = 1'b1;
    for (int k = 0; k < 4; k++) preload(32'h600 + 32'(k) * 4, $urandom);
    run_copy(32'h600, 32'h700, 4, 5, 1'b0);

    // Reset while waiting on the second word's write response
    stall_en = 1'b0;
    start_copy(32'h100, 32'h800, 4, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (memreq_val && memreq_rdy && req_m.t == MEM_TYPE_WRITE && req_m.op == 8'h01) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("reset_test_no_write1");
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_req_q.delete();
    exp_done_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_go_rdy", go_rdy, 1'b1);
    ref_mem = tb_mem;
    repeat (2) @(posedge clk);
    run_copy(32'h104, 32'h900, 1, 0, 1'b0);

    // Responder returns a wrong opaque on the first read
    preload(32'hA00, 32'h5A5A_5A5A);
    preload(32'hA04, 32'hA5A5_A5A5);
    corrupt_once = 1'b1;
    run_copy(32'hA00, 32'hB00, 2, 0, EXP_ERR_ON_CORRUPT);

    // Randomised copies with stalls; next go clears the sticky error
    stall_en = 1'b1;
    for (int it = 0; it < 6; it++) begin
      n = int'($urandom_range(1, 8));
      s = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
      d = 32'h4000 + 32'($urandom_range(0, 63)) * 4;
      for (int k = 0; k < n; k++) preload(s + 32'(k) * 4, $urandom);
      run_copy(s, d, n, int'($urandom_range(0, 3)), 1'b0);
    end
    stall_en = 1'b0;

    repeat (5) @(posedge clk);
    check("req_queue_drained", 32'(exp_req_q.size()), 32'd0);
    check("done_queue_drained", 32'(exp_done_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sm_mem_copy_engine.md
Name: sm_mem_copy_engine

Overview:
- Memory-request initiator that copies a block of words from a source region to a destination region.
- Uses the team's standard memory req/resp message format, including the response addr field.
- Sits opposite a memory responder such as the single-port test memory. Takes a go command via val/rdy and reports completion via val/rdy.
- One transaction outstanding at a time: read word i, then write word i, then advance.

Parameters:
- p_opaque_nbits, 8, memory message opaque field width (o)
- p_addr_nbits, 32, memory message address width (a)
- p_data_nbits, 32, memory message data width (d); word size is d/8 bytes
- p_count_nbits, 16, width of the word-count field

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (0 = reset asserted)
- go_val  in  1  copy command valid
- go_rdy  out  1  engine can accept a command
- go_src  in  a  source byte address
- go_dst  in  a  destination byte address
- go_nwords  in  p_count_nbits  number of words to copy
- done_val  out  1  copy complete
- done_rdy  in  1  completion accepted
- done_err  out  1  sticky response-check error, valid with done_val
- busy  out  1  high in any state except IDLE
- memreq_val/memreq_rdy/memreq_msg  out/in/out  1/1/REQ_NBITS(o,a,d)  request port
- memresp_val/memresp_rdy/memresp_msg  in/out/in  1/1/RESP_NBITS(o,a,d)  response port

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: state=IDLE, i=0, err=0. Outputs go_rdy=1, done_val=0, memreq_val=0, memresp_rdy=0, busy=0.
- A reset mid-copy abandons the copy and returns to IDLE on the next edge.
- Responses arriving in IDLE stall, because memresp_rdy=0. The bench resets the memory together with the engine.
- IDLE:
  - go_rdy=1.
  - On go_val&&go_rdy, latch src, dst and n; clear i and err.
  - If n==0, go to DONE; otherwise go to RD_REQ.
- RD_REQ:
  - memreq_val=1 with type=READ, opaque=i[o-1:0], addr=src+i*(d/8), len=0, data=0.
  - On memreq_rdy, go to RD_WAIT.
- RD_WAIT:
  - memresp_rdy=1.
  - On memresp_val, latch resp data into wdata and go to WR_REQ.
- WR_REQ:
  - memreq_val=1 with type=WRITE, opaque=i[o-1:0], addr=dst+i*(d/8), len=0, data=wdata.
  - On memreq_rdy, go to WR_WAIT.
- WR_WAIT:
  - memresp_rdy=1.
  - On memresp_val, i<=i+1. If i+1==n go to DONE, else go to RD_REQ.
- DONE:
  - done_val=1 and done_err=err.
  - On done_rdy, go to IDLE.
  - go_rdy=0 in every state except IDLE.
- Handshake rules:
  - memreq_msg is held stable while memreq_val=1 and memreq_rdy=0.
  - A transfer occurs only on val&&rdy at a posedge.
  - memreq_val never depends combinationally on memreq_rdy.
- Minimum cost with a zero-wait responder: 4 cycles per word (req, resp, req, resp), plus 1 cycle in DONE.
- Address arithmetic is modulo 2^a; addresses wrap silently past the top of the space.
- i is p_count_nbits wide. n = 2^p_count_nbits-1 is legal; the terminal compare uses i+1 computed at p_count_nbits+1 bits.
- Opaque wraps mod 2^o and is informational only.
- go_val while busy is ignored (not accepted).
- done_val and go_val cannot overlap, because DONE precedes IDLE.

Optional Feature:
- Macro: SM_MEM_COPY_ENGINE_CHECK_EN.
- Defined: on every accepted response, set err (sticky until the next go) if any of these mismatch:
  - resp.opaque != i[o-1:0]
  - resp.type != the issued type
  - resp.addr != the issued addr
  - Also emit VC_ASSERT_NOT_X on memresp_val and done_rdy when reset is deasserted.
- Undefined: no comparison logic; done_err is tied to 0.

Decomposition:
- Shared mem-msgs package/header supplies:
  - message-type constants (READ, WRITE, ...)
  - REQ/RESP field-width macros
  - the pack/unpack modules, which are reused directly
- FSM state encoding localparams are kept in this module.
- One natural sub-module: sm_mem_copy_engine_addrgen. It holds latched src/dst/n and counter i, and produces rd_addr, wr_addr, opaque and the last flag.
- The FSM and message packing stay in the top module.

Test Plan:
- Memory preloaded at 0x100..0x10C with 0x11,0x22,0x33,0x44; go src=0x100 dst=0x200 n=4 -> 0x200..0x20C read back 0x11..0x44; done_val asserted; done_err=0; exactly 8 requests issued.
- go n=0 -> no memreq_val ever; done_val asserted one cycle after acceptance; done_err=0.
- Random memreq_rdy/memresp_val stalls and done_rdy held low 5 cycles -> data still correct; memreq_msg stable during stall; done_val held until done_rdy.
- src=0xFFFFFFFC n=2 -> second read addr is 0x00000000 (wrap); copied data correct.
- Reset asserted (0) in WR_WAIT at word 2 of 4 -> next cycle busy=0, go_rdy=1; a following go of n=1 completes normally.
- CHECK_EN defined, responder returns opaque 0x05 when 0x00 expected -> done_err=1; with the macro undefined -> done_err=0.
